issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Issue stage directly downstream of the decoded-instruction queue (queue_comps).
- Reads the queue head and checks RAW/WAW hazards against a per-register busy scoreboard.
- Forwards same-cycle writeback data into operands, pops the queue, and holds one issued instruction in an output register under a valid/ready handshake to the execute stage.

Parameters:
- DWIDTH, 32, register data width
- AWIDTH, 5, register address width; scoreboard depth 2**AWIDTH
- PC_WIDTH, 32, program counter width
- IMM_WIDTH, 16, immediate width
- CNT_WIDTH, 16, stall counter width

Ports:
- qc_clk  in  1  clock, posedge
- qc_rst  in  1  reset, asynchronous, active-low
- is_i_valid  in  1  queue non-empty, head fields valid
- is_i_ce, is_i_reg_dst, is_i_alu_src, is_i_regwrite, is_i_memtoreg, is_i_memwrite  in  1 each  head control bits
- is_i_pc  in  PC_WIDTH  head PC
- is_i_opcode / is_i_funct  in  6 / 6  head opcode, funct
- is_i_imm  in  IMM_WIDTH  head immediate
- is_i_addr_rs, is_i_addr_rt, is_i_addr_rd  in  AWIDTH each  head register addresses
- is_i_data_rs, is_i_data_rt  in  DWIDTH each  head operand data
- is_o_re  out  1  combinational pop strobe to queue (qc_i_re)
- is_i_wb_en  in  1  writeback valid
- is_i_wb_addr  in  AWIDTH  writeback register
- is_i_wb_data  in  DWIDTH  writeback data
- is_i_flush  in  1  synchronous flush
- is_i_ex_ready  in  1  execute stage accepts
- is_o_valid  out  1  output register holds an instruction
- is_o_pc, is_o_opcode, is_o_funct, is_o_imm, is_o_data_rs, is_o_data_rt  out  matching widths  issued fields
- is_o_dest  out  AWIDTH  resolved destination
- is_o_alu_src, is_o_regwrite, is_o_memtoreg, is_o_memwrite  out  1 each  issued control bits
- is_o_stall_cnt  out  CNT_WIDTH  hazard stall cycles

Behaviour:
- Reset (async, qc_rst low): all outputs 0, busy[] all 0, stall counter 0; effective immediately, mid-operation included.
- dest = is_i_reg_dst ? addr_rd : addr_rt. Writes to r0 never mark busy; busy[0] reads 0.
- Operand use: rs used when ce=1; rt used when alu_src=0 or memwrite=1.
- Hazard = (rs used & busy'[rs]) | (rt used & busy'[rt]) | (regwrite & busy'[dest]). busy' is busy with bit wb_addr cleared when wb_en=1 (same-cycle bypass).
- Forwarding: a used operand whose address equals wb_addr (wb_en=1, addr≠0) takes is_i_wb_data instead of queue data.
- slot_free = !is_o_valid | is_i_ex_ready.
- Bubble: is_i_valid & !ce & !flush gives is_o_re=1 with no issue and no scoreboard change.
- Issue: is_i_valid & ce & !hazard & slot_free & !flush. Effects:
  - is_o_re=1 that cycle; the queue advances on the following negedge.
  - Output register loads at the next posedge; is_o_valid=1.
  - busy[dest] is set if regwrite and dest≠0.
- Output hold: is_o_valid stays set and fields stay stable until is_i_ex_ready=1. On accept with no new issue, is_o_valid goes to 0 at the next posedge. Accept and issue in the same cycle are back-to-back with no bubble.
- Writeback clears busy[wb_addr] at posedge. If the same cycle issues to the same dest, set wins.
- Flush: is_o_re=0. If is_o_valid & !ex_ready, clear busy of the held dest. is_o_valid goes to 0. Other busy bits are kept, because in-flight instructions still write back.
- Stall counter: increments each cycle with is_i_valid & ce & hazard & !flush; saturates at all-ones.
- is_i_valid=0: is_o_re=0 and no state change except handshake and writeback.

Test Plan:
- Reset: pulse qc_rst low mid-hold with is_o_valid=1 -> all outputs 0, busy cleared, stall_cnt=0 immediately.
- Independent ops: add r3=r1+r2 then add r4=r5+r6 (reg_dst=1, alu_src=0, regwrite=1), ex_ready=1 -> two consecutive is_o_re pulses; is_o_valid high two cycles; is_o_dest=3 then 4.
- RAW stall: add r3 issued, then sub r7=r3-r1 at head, no writeback for 3 cycles -> is_o_re=0 for those cycles, stall_cnt=3. Writeback r3=0x55 in cycle 4 -> sub issues that cycle with is_o_data_rs=0x55.
- Backpressure: ex_ready=0 for 4 cycles with is_o_valid=1 -> outputs stable, is_o_re=0. ex_ready=1 -> next instruction loads the next cycle.
- r0 destination and bubble:
  - addi r0 (reg_dst=0, rt=0) issues; the following read of r0 does not stall.
  - Head ce=0 -> is_o_re=1, is_o_valid unchanged.
- Flush: hold add r9 with ex_ready=0, assert flush -> is_o_valid=0 and busy[9]=0. A following read of r9 issues without stall.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue stage: checks the queue head against a per-register busy scoreboard,
// forwards same-cycle writeback data into operands, and holds one issued
// instruction in an output register until the execute stage accepts it.
module issue_scoreboard #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 qc_clk,
  input  logic                 qc_rst,
  input  logic                 is_i_valid,
  input  logic                 is_i_ce,
  input  logic                 is_i_reg_dst,
  input  logic                 is_i_alu_src,
  input  logic                 is_i_regwrite,
  input  logic                 is_i_memtoreg,
  input  logic                 is_i_memwrite,
  input  logic [PC_WIDTH-1:0]  is_i_pc,
  input  logic [5:0]           is_i_opcode,
  input  logic [5:0]           is_i_funct,
  input  logic [IMM_WIDTH-1:0] is_i_imm,
  input  logic [AWIDTH-1:0]    is_i_addr_rs,
  input  logic [AWIDTH-1:0]    is_i_addr_rt,
  input  logic [AWIDTH-1:0]    is_i_addr_rd,
  input  logic [DWIDTH-1:0]    is_i_data_rs,
  input  logic [DWIDTH-1:0]    is_i_data_rt,
  output logic                 is_o_re,
  input  logic                 is_i_wb_en,
  input  logic [AWIDTH-1:0]    is_i_wb_addr,
  input  logic [DWIDTH-1:0]    is_i_wb_data,
  input  logic                 is_i_flush,
  input  logic                 is_i_ex_ready,
  output logic                 is_o_valid,
  output logic [PC_WIDTH-1:0]  is_o_pc,
  output logic [5:0]           is_o_opcode,
  output logic [5:0]           is_o_funct,
  output logic [IMM_WIDTH-1:0] is_o_imm,
  output logic [DWIDTH-1:0]    is_o_data_rs,
  output logic [DWIDTH-1:0]    is_o_data_rt,
  output logic [AWIDTH-1:0]    is_o_dest,
  output logic                 is_o_alu_src,
  output logic                 is_o_regwrite,
  output logic                 is_o_memtoreg,
  output logic                 is_o_memwrite,
  output logic [CNT_WIDTH-1:0] is_o_stall_cnt
);

  localparam int NREG = 2 ** AWIDTH;

  logic [NREG-1:0]      busy_q, busy_d, busy_byp;
  logic [AWIDTH-1:0]    dest;
  logic                 use_rs, use_rt, hazard, slot_free, bubble, issue;
  logic                 fwd_rs, fwd_rt;
  logic [DWIDTH-1:0]    op_rs, op_rt;

  logic                 valid_q, valid_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [5:0]           opcode_q, opcode_d, funct_q, funct_d;
  logic [IMM_WIDTH-1:0] imm_q, imm_d;
  logic [DWIDTH-1:0]    data_rs_q, data_rs_d, data_rt_q, data_rt_d;
  logic [AWIDTH-1:0]    dest_q, dest_d;
  logic                 alu_src_q, alu_src_d, regwrite_q, regwrite_d;
  logic                 memtoreg_q, memtoreg_d, memwrite_q, memwrite_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  // Hazard detection against the scoreboard with same-cycle writeback bypass.
  always_comb begin
    busy_byp = busy_q;
    if (is_i_wb_en) busy_byp[is_i_wb_addr] = 1'b0;
    busy_byp[0] = 1'b0;
    dest      = is_i_reg_dst ? is_i_addr_rd : is_i_addr_rt;
    use_rs    = is_i_ce;
    use_rt    = !is_i_alu_src || is_i_memwrite;
    hazard    = (use_rs && busy_byp[is_i_addr_rs]) ||
                (use_rt && busy_byp[is_i_addr_rt]) ||
                (is_i_regwrite && busy_byp[dest]);
    slot_free = !valid_q || is_i_ex_ready;
    bubble    = is_i_valid && !is_i_ce && !is_i_flush;
    issue     = is_i_valid && is_i_ce && !hazard && slot_free && !is_i_flush;
    fwd_rs    = use_rs && is_i_wb_en && (is_i_wb_addr != '0) && (is_i_wb_addr == is_i_addr_rs);
    fwd_rt    = use_rt && is_i_wb_en && (is_i_wb_addr != '0) && (is_i_wb_addr == is_i_addr_rt);
    op_rs     = fwd_rs ? is_i_wb_data : is_i_data_rs;
    op_rt     = fwd_rt ? is_i_wb_data : is_i_data_rt;
  end

  // Pop is held low while in reset so every output reads 0 immediately.
  assign is_o_re = qc_rst && (bubble || issue);

  // Next-state for scoreboard, output register and stall counter.
  always_comb begin
    busy_d     = busy_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    imm_d      = imm_q;
    data_rs_d  = data_rs_q;
    data_rt_d  = data_rt_q;
    dest_d     = dest_q;
    alu_src_d  = alu_src_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    stall_d    = stall_q;

    if (is_i_wb_en) busy_d[is_i_wb_addr] = 1'b0;
    // A flushed, never-accepted instruction will not write back, so its
    // reservation is released; accepted ones stay in flight and keep theirs.
    if (is_i_flush && valid_q && !is_i_ex_ready && regwrite_q) busy_d[dest_q] = 1'b0;
    if (issue && is_i_regwrite) busy_d[dest] = 1'b1;
    busy_d[0] = 1'b0;

    if (is_i_flush) begin
      valid_d = 1'b0;
    end else if (issue) begin
      valid_d    = 1'b1;
      pc_d       = is_i_pc;
      opcode_d   = is_i_opcode;
      funct_d    = is_i_funct;
      imm_d      = is_i_imm;
      data_rs_d  = op_rs;
      data_rt_d  = op_rt;
      dest_d     = dest;
      alu_src_d  = is_i_alu_src;
      regwrite_d = is_i_regwrite;
      memtoreg_d = is_i_memtoreg;
      memwrite_d = is_i_memwrite;
    end else if (is_i_ex_ready) begin
      valid_d = 1'b0;
    end

    if (is_i_valid && is_i_ce && hazard && !is_i_flush && (stall_q != '1))
      stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge qc_clk or negedge qc_rst) begin
    if (!qc_rst) begin
      busy_q     <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      opcode_q   <= '0;
      funct_q    <= '0;
      imm_q      <= '0;
      data_rs_q  <= '0;
      data_rt_q  <= '0;
      dest_q     <= '0;
      alu_src_q  <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
      imm_q      <= imm_d;
      data_rs_q  <= data_rs_d;
      data_rt_q  <= data_rt_d;
      dest_q     <= dest_d;
      alu_src_q  <= alu_src_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      stall_q    <= stall_d;
    end
  end

  assign is_o_valid     = valid_q;
  assign is_o_pc        = pc_q;
  assign is_o_opcode    = opcode_q;
  assign is_o_funct     = funct_q;
  assign is_o_imm       = imm_q;
  assign is_o_data_rs   = data_rs_q;
  assign is_o_data_rt   = data_rt_q;
  assign is_o_dest      = dest_q;
  assign is_o_alu_src   = alu_src_q;
  assign is_o_regwrite  = regwrite_q;
  assign is_o_memtoreg  = memtoreg_q;
  assign is_o_memwrite  = memwrite_q;
  assign is_o_stall_cnt = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, reset-mid-hold sequence,
// then random traffic compared against a rule-level reference model.
module tb_issue_scoreboard;

  logic        qc_clk = 1'b0;
  logic        qc_rst = 1'b0;
  logic        is_i_valid, is_i_ce, is_i_reg_dst, is_i_alu_src, is_i_regwrite;
  logic        is_i_memtoreg, is_i_memwrite;
  logic [31:0] is_i_pc;
  logic [5:0]  is_i_opcode, is_i_funct;
  logic [15:0] is_i_imm;
  logic [4:0]  is_i_addr_rs, is_i_addr_rt, is_i_addr_rd;
  logic [31:0] is_i_data_rs, is_i_data_rt;
  logic        is_o_re;
  logic        is_i_wb_en;
  logic [4:0]  is_i_wb_addr;
  logic [31:0] is_i_wb_data;
  logic        is_i_flush, is_i_ex_ready;
  logic        is_o_valid;
  logic [31:0] is_o_pc;
  logic [5:0]  is_o_opcode, is_o_funct;
  logic [15:0] is_o_imm;
  logic [31:0] is_o_data_rs, is_o_data_rt;
  logic [4:0]  is_o_dest;
  logic        is_o_alu_src, is_o_regwrite, is_o_memtoreg, is_o_memwrite;
  logic [15:0] is_o_stall_cnt;

  issue_scoreboard dut (
    .qc_clk(qc_clk), .qc_rst(qc_rst),
    .is_i_valid(is_i_valid), .is_i_ce(is_i_ce), .is_i_reg_dst(is_i_reg_dst),
    .is_i_alu_src(is_i_alu_src), .is_i_regwrite(is_i_regwrite),
    .is_i_memtoreg(is_i_memtoreg), .is_i_memwrite(is_i_memwrite),
    .is_i_pc(is_i_pc), .is_i_opcode(is_i_opcode), .is_i_funct(is_i_funct),
    .is_i_imm(is_i_imm), .is_i_addr_rs(is_i_addr_rs), .is_i_addr_rt(is_i_addr_rt),
    .is_i_addr_rd(is_i_addr_rd), .is_i_data_rs(is_i_data_rs), .is_i_data_rt(is_i_data_rt),
    .is_o_re(is_o_re), .is_i_wb_en(is_i_wb_en), .is_i_wb_addr(is_i_wb_addr),
    .is_i_wb_data(is_i_wb_data), .is_i_flush(is_i_flush), .is_i_ex_ready(is_i_ex_ready),
    .is_o_valid(is_o_valid), .is_o_pc(is_o_pc), .is_o_opcode(is_o_opcode),
    .is_o_funct(is_o_funct), .is_o_imm(is_o_imm), .is_o_data_rs(is_o_data_rs),
    .is_o_data_rt(is_o_data_rt), .is_o_dest(is_o_dest), .is_o_alu_src(is_o_alu_src),
    .is_o_regwrite(is_o_regwrite), .is_o_memtoreg(is_o_memtoreg),
    .is_o_memwrite(is_o_memwrite), .is_o_stall_cnt(is_o_stall_cnt)
  );

  always #5 qc_clk = ~qc_clk;

  typedef struct {
    logic        v, ce, rdst, asrc, rw, mw, flush, rdy, wbe;
    logic [4:0]  rs, rt, rd, wba;
    logic [31:0] drs, wbd;
    logic        exp_re, exp_v;
    logic [4:0]  exp_dest;
    logic [15:0] exp_stall;
    logic [31:0] exp_drs;
  } vec_t;

  vec_t tbl[19];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] drs, input logic rdy);
    vec_t t;
    t = '{default: '0};
    t.v = 1'b1; t.ce = 1'b1; t.rdst = 1'b1; t.asrc = 1'b0; t.rw = 1'b1;
    t.rs = rs; t.rt = rt; t.rd = rd; t.drs = drs; t.rdy = rdy;
    return t;
  endfunction

  function automatic vec_t ex(input vec_t t, input logic re, input logic v,
                              input logic [4:0] dest, input logic [15:0] st, input logic [31:0] drs);
    vec_t r;
    r = t;
    r.exp_re = re; r.exp_v = v; r.exp_dest = dest; r.exp_stall = st; r.exp_drs = drs;
    return r;
  endfunction

  task automatic drive_idle();
    is_i_valid = 0; is_i_ce = 0; is_i_reg_dst = 0; is_i_alu_src = 0; is_i_regwrite = 0;
    is_i_memtoreg = 0; is_i_memwrite = 0; is_i_pc = 0; is_i_opcode = 0; is_i_funct = 0;
    is_i_imm = 0; is_i_addr_rs = 0; is_i_addr_rt = 0; is_i_addr_rd = 0;
    is_i_data_rs = 0; is_i_data_rt = 0; is_i_wb_en = 0; is_i_wb_addr = 0;
    is_i_wb_data = 0; is_i_flush = 0; is_i_ex_ready = 0;
  endtask

  task automatic drive_vec(input vec_t t);
    drive_idle();
    is_i_valid = t.v; is_i_ce = t.ce; is_i_reg_dst = t.rdst; is_i_alu_src = t.asrc;
    is_i_regwrite = t.rw; is_i_memwrite = t.mw; is_i_flush = t.flush; is_i_ex_ready = t.rdy;
    is_i_wb_en = t.wbe; is_i_wb_addr = t.wba; is_i_wb_data = t.wbd;
    is_i_addr_rs = t.rs; is_i_addr_rt = t.rt; is_i_addr_rd = t.rd; is_i_data_rs = t.drs;
  endtask

  // reference model state
  bit          m_busy[32];
  bit          m_valid, m_rw, m_asrc, m_mtr, m_mw;
  logic [4:0]  m_dest;
  logic [31:0] m_pc, m_drs, m_drt;
  logic [5:0]  m_opc, m_fn;
  logic [15:0] m_imm;
  int          m_stall;

  function automatic bit still_busy(input logic [4:0] a);
    return (a != 0) && m_busy[a] && !(is_i_wb_en && is_i_wb_addr == a);
  endfunction

  initial begin
    vec_t t;
    logic [4:0]  dst;
    bit          urs, urt, hz, free, iss, exp_re;

    // r3 = r1 + r2, r4 = r5 + r6 back to back
    tbl[0]  = ex(op(1, 2, 3, 32'h11, 1), 1, 1, 3, 0, 32'h11);
    tbl[1]  = ex(op(5, 6, 4, 32'h22, 1), 1, 1, 4, 0, 32'h22);
    // sub r7 = r3 - r1 stalls three cycles, then issues with forwarded r3
    tbl[2]  = ex(op(3, 1, 7, 32'h33, 1), 0, 0, 0, 1, 0);
    tbl[3]  = ex(op(3, 1, 7, 32'h33, 1), 0, 0, 0, 2, 0);
    tbl[4]  = ex(op(3, 1, 7, 32'h33, 1), 0, 0, 0, 3, 0);
    t = op(3, 1, 7, 32'h33, 1); t.wbe = 1; t.wba = 3; t.wbd = 32'h55;
    tbl[5]  = ex(t, 1, 1, 7, 3, 32'h55);
    // backpressure: held sub stays put for four cycles
    tbl[6]  = ex(op(1, 2, 8, 32'h66, 0), 0, 1, 7, 3, 32'h55);
    tbl[7]  = ex(op(1, 2, 8, 32'h66, 0), 0, 1, 7, 3, 32'h55);
    tbl[8]  = ex(op(1, 2, 8, 32'h66, 0), 0, 1, 7, 3, 32'h55);
    tbl[9]  = ex(op(1, 2, 8, 32'h66, 0), 0, 1, 7, 3, 32'h55);
    tbl[10] = ex(op(1, 2, 8, 32'h66, 1), 1, 1, 8, 3, 32'h66);
    // addi r0: never marks busy; then read r0 without stall
    t = op(1, 0, 0, 32'h77, 1); t.rdst = 0; t.asrc = 1;
    tbl[11] = ex(t, 1, 1, 0, 3, 32'h77);
    tbl[12] = ex(op(0, 0, 9, 32'h88, 1), 1, 1, 9, 3, 32'h88);
    // bubble with held add r9
    t = op(0, 0, 9, 32'h0, 0); t.ce = 0;
    tbl[13] = ex(t, 1, 1, 9, 3, 32'h88);
    // flush while holding r9, then reader of r9 issues immediately
    t = op(9, 1, 10, 32'h99, 0); t.flush = 1;
    tbl[14] = ex(t, 0, 0, 0, 3, 0);
    tbl[15] = ex(op(9, 1, 10, 32'h99, 1), 1, 1, 10, 3, 32'h99);
    t = op(0, 0, 0, 0, 1); t.v = 0;
    tbl[16] = ex(t, 0, 0, 0, 3, 0);
    // WAW on busy r4; writeback of r4 in same cycle as re-issue leaves r4 busy
    tbl[17] = ex(op(1, 2, 4, 32'h44, 1), 0, 0, 0, 4, 0);
    t = op(1, 2, 4, 32'h44, 0); t.wbe = 1; t.wba = 4; t.wbd = 32'hAB;
    tbl[18] = ex(t, 1, 1, 4, 4, 32'h44);

    drive_idle();
    #12;
    chk("reset_valid", is_o_valid, 0);
    chk("reset_re", is_o_re, 0);
    @(negedge qc_clk); qc_rst = 1'b1;

    foreach (tbl[i]) begin
      drive_vec(tbl[i]);
      #1;
      chk($sformatf("tbl%0d_re", i), is_o_re, tbl[i].exp_re);
      @(posedge qc_clk); #1;
      chk($sformatf("tbl%0d_valid", i), is_o_valid, tbl[i].exp_v);
      chk($sformatf("tbl%0d_stall", i), is_o_stall_cnt, tbl[i].exp_stall);
      if (tbl[i].exp_v) begin
        chk($sformatf("tbl%0d_dest", i), is_o_dest, tbl[i].exp_dest);
        chk($sformatf("tbl%0d_drs", i), is_o_data_rs, tbl[i].exp_drs);
      end
      @(negedge qc_clk);
    end

    // reset mid-hold: add r4 held, r4 busy, head r5 = r4 + r1 blocked
    drive_vec(op(4, 1, 5, 32'h5A, 0));
    #1;
    chk("pre_rst_re", is_o_re, 0);
    chk("pre_rst_valid", is_o_valid, 1);
    #1; qc_rst = 1'b0; #1;
    chk("rst_valid", is_o_valid, 0);
    chk("rst_re", is_o_re, 0);
    chk("rst_stall", is_o_stall_cnt, 0);
    chk("rst_dest", is_o_dest, 0);
    chk("rst_drs", is_o_data_rs, 0);
    @(negedge qc_clk); qc_rst = 1'b1;
    is_i_ex_ready = 1;
    #1;
    chk("post_rst_re", is_o_re, 1);
    @(posedge qc_clk); #1;
    chk("post_rst_valid", is_o_valid, 1);
    chk("post_rst_dest", is_o_dest, 5);
    chk("post_rst_stall", is_o_stall_cnt, 0);

    // randomized phase from a clean reset
    @(negedge qc_clk);
    drive_idle();
    qc_rst = 1'b0; #2; qc_rst = 1'b1;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_valid = 0; m_rw = 0; m_asrc = 0; m_mtr = 0; m_mw = 0; m_dest = 0;
    m_pc = 0; m_drs = 0; m_drt = 0; m_opc = 0; m_fn = 0; m_imm = 0; m_stall = 0;

    for (int n = 0; n < 3000; n++) begin
      @(negedge qc_clk);
      is_i_valid    = ($urandom_range(0, 9) < 8);
      is_i_ce       = ($urandom_range(0, 9) < 9);
      is_i_reg_dst  = $urandom_range(0, 1);
      is_i_alu_src  = $urandom_range(0, 1);
      is_i_regwrite = ($urandom_range(0, 3) != 0);
      is_i_memtoreg = $urandom_range(0, 1);
      is_i_memwrite = ($urandom_range(0, 3) == 0);
      is_i_pc       = $urandom;
      is_i_opcode   = 6'($urandom);
      is_i_funct    = 6'($urandom);
      is_i_imm      = 16'($urandom);
      is_i_addr_rs  = 5'($urandom_range(0, 3));
      is_i_addr_rt  = 5'($urandom_range(0, 3));
      is_i_addr_rd  = 5'($urandom_range(0, 3));
      is_i_data_rs  = $urandom;
      is_i_data_rt  = $urandom;
      is_i_wb_en    = ($urandom_range(0, 9) < 4);
      is_i_wb_addr  = 5'($urandom_range(0, 3));
      is_i_wb_data  = $urandom;
      is_i_flush    = ($urandom_range(0, 19) == 0);
      is_i_ex_ready = ($urandom_range(0, 9) < 7);
      #1;
      dst    = is_i_reg_dst ? is_i_addr_rd : is_i_addr_rt;
      urs    = is_i_ce;
      urt    = !is_i_alu_src || is_i_memwrite;
      hz     = (urs && still_busy(is_i_addr_rs)) || (urt && still_busy(is_i_addr_rt)) ||
               (is_i_regwrite && still_busy(dst));
      free   = !m_valid || is_i_ex_ready;
      iss    = is_i_valid && is_i_ce && !hz && free && !is_i_flush;
      exp_re = is_i_valid && !is_i_flush && (!is_i_ce || iss);
      chk("rnd_re", is_o_re, exp_re);

      if (is_i_valid && is_i_ce && hz && !is_i_flush && m_stall < 65535) m_stall++;
      if (is_i_wb_en) m_busy[is_i_wb_addr] = 0;
      if (is_i_flush && m_valid && !is_i_ex_ready && m_rw) m_busy[m_dest] = 0;
      if (iss && is_i_regwrite && dst != 0) m_busy[dst] = 1;
      if (is_i_flush) m_valid = 0;
      else if (iss) begin
        m_valid = 1; m_pc = is_i_pc; m_opc = is_i_opcode; m_fn = is_i_funct; m_imm = is_i_imm;
        m_drs = (urs && is_i_wb_en && is_i_wb_addr != 0 && is_i_wb_addr == is_i_addr_rs)
                ? is_i_wb_data : is_i_data_rs;
        m_drt = (urt && is_i_wb_en && is_i_wb_addr != 0 && is_i_wb_addr == is_i_addr_rt)
                ? is_i_wb_data : is_i_data_rt;
        m_dest = dst; m_asrc = is_i_alu_src; m_rw = is_i_regwrite;
        m_mtr = is_i_memtoreg; m_mw = is_i_memwrite;
      end else if (is_i_ex_ready) m_valid = 0;

      @(posedge qc_clk); #1;
      chk("rnd_valid", is_o_valid, m_valid);
      chk("rnd_stall", is_o_stall_cnt, 16'(m_stall));
      if (m_valid) begin
        chk("rnd_pc", is_o_pc, m_pc);
        chk("rnd_opcode", is_o_opcode, m_opc);
        chk("rnd_funct", is_o_funct, m_fn);
        chk("rnd_imm", is_o_imm, m_imm);
        chk("rnd_drs", is_o_data_rs, m_drs);
        chk("rnd_drt", is_o_data_rt, m_drt);
        chk("rnd_dest", is_o_dest, m_dest);
        chk("rnd_ctl", {is_o_alu_src, is_o_regwrite, is_o_memtoreg, is_o_memwrite},
            {m_asrc, m_rw, m_mtr, m_mw});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
